// File: rtl/sha_handshake_bridge.sv
// Bridge between a valid-ready byte FIFO and four-phase activate/data/digest
// channels of an asynchronous SHA core; all incoming req/ack lines are synchronised.
module sha_handshake_bridge #(
  parameter int DATA_W      = 8,
  parameter int DIGEST_W    = 256,
  parameter int DEPTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     initialise,
  input  logic                     start,
  output logic                     busy,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     activate_0r,
  input  logic                     activate_0a,
  input  logic                     data_0r,
  output logic                     data_0a,
  output logic [DATA_W-1:0]        data_0d,
  input  logic                     digest_0r,
  output logic                     digest_0a,
  input  logic [DIGEST_W-1:0]      digest_0d,
  output logic                     dig_valid,
  output logic [DIGEST_W-1:0]      dig_data,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic                     underrun
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {A_IDLE, A_REQ, A_REL} a_state_t;
  typedef enum logic [1:0] {D_IDLE, D_SETUP, D_ACK} d_state_t;
  typedef enum logic {G_IDLE, G_ACK} g_state_t;

  a_state_t a_state;
  d_state_t d_state;
  g_state_t g_state;

  logic [SYNC_STAGES-1:0] act_sync;
  logic [SYNC_STAGES-1:0] dreq_sync;
  logic [SYNC_STAGES-1:0] greq_sync;
  logic act_s, dreq_s, greq_s;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic live;
  logic push, pop;

  assign act_s  = act_sync[SYNC_STAGES-1];
  assign dreq_s = dreq_sync[SYNC_STAGES-1];
  assign greq_s = greq_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge initialise) begin
    if (initialise) begin
      act_sync  <= '0;
      dreq_sync <= '0;
      greq_sync <= '0;
    end else begin
      act_sync  <= {act_sync[SYNC_STAGES-2:0], activate_0a};
      dreq_sync <= {dreq_sync[SYNC_STAGES-2:0], data_0r};
      greq_sync <= {greq_sync[SYNC_STAGES-2:0], digest_0r};
    end
  end

  // live holds wr_ready low until the first edge after reset release
  assign wr_ready = live && (fill_level != FULL);
  assign push     = wr_valid && wr_ready;
  assign pop      = (d_state == D_IDLE) && dreq_s && (fill_level != '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge initialise) begin
    if (initialise) begin
      live       <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_level <= '0;
    end else begin
      live <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   fill_level <= fill_level + 1'b1;
        2'b01:   fill_level <= fill_level - 1'b1;
        default: fill_level <= fill_level;
      endcase
    end
  end

  always_ff @(posedge clk or posedge initialise) begin
    if (initialise) begin
      a_state     <= A_IDLE;
      activate_0r <= 1'b0;
      busy        <= 1'b0;
    end else begin
      unique case (a_state)
        A_IDLE: if (start) begin
          a_state     <= A_REQ;
          activate_0r <= 1'b1;
          busy        <= 1'b1;
        end
        A_REQ: if (act_s) begin
          a_state     <= A_REL;
          activate_0r <= 1'b0;
        end
        A_REL: if (!act_s) begin
          a_state <= A_IDLE;
          busy    <= 1'b0;
        end
        default: a_state <= A_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge initialise) begin
    if (initialise) begin
      d_state  <= D_IDLE;
      data_0a  <= 1'b0;
      data_0d  <= '0;
      underrun <= 1'b0;
    end else begin
      unique case (d_state)
        D_IDLE: begin
          if (pop) begin
            data_0d <= mem[rd_ptr];
            d_state <= D_SETUP;
          end else if (dreq_s) begin
            underrun <= 1'b1;
          end
        end
        D_SETUP: begin
          d_state <= D_ACK;
          data_0a <= 1'b1;
        end
        D_ACK: if (!dreq_s) begin
          d_state <= D_IDLE;
          data_0a <= 1'b0;
        end
        default: d_state <= D_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge initialise) begin
    if (initialise) begin
      g_state   <= G_IDLE;
      digest_0a <= 1'b0;
      dig_valid <= 1'b0;
      dig_data  <= '0;
    end else begin
      dig_valid <= 1'b0;
      unique case (g_state)
        G_IDLE: if (greq_s) begin
          dig_data  <= digest_0d;
          dig_valid <= 1'b1;
          digest_0a <= 1'b1;
          g_state   <= G_ACK;
        end
        G_ACK: if (!greq_s) begin
          digest_0a <= 1'b0;
          g_state   <= G_IDLE;
        end
        default: g_state <= G_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha_handshake_bridge.sv
// Scoreboard bench for sha_handshake_bridge: FIFO order, wrap, underrun,
// digest capture, activate handshake and asynchronous reset.
module tb_sha_handshake_bridge;
  localparam int DW = 8;
  localparam int GW = 256;
  localparam int DEPTH = 16;
  localparam int SS = 2;

  logic clk = 1'b0;
  logic initialise = 1'b1;
  logic start = 1'b0;
  logic busy;
  logic wr_valid = 1'b0;
  logic wr_ready;
  logic [DW-1:0] wr_data = '0;
  logic activate_0r;
  logic activate_0a = 1'b0;
  logic data_0r = 1'b0;
  logic data_0a;
  logic [DW-1:0] data_0d;
  logic digest_0r = 1'b0;
  logic digest_0a;
  logic [GW-1:0] digest_0d = '0;
  logic dig_valid;
  logic [GW-1:0] dig_data;
  logic [$clog2(DEPTH):0] fill_level;
  logic underrun;

  int checks = 0;
  int passed = 0;
  int act_rises = 0;
  logic [DW-1:0] exp_q[$];
  logic [GW-1:0] dig_q[$];

  localparam logic [GW-1:0] SHA_ABC =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [GW-1:0] SHA_EMPTY =
    256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

  sha_handshake_bridge #(
    .DATA_W(DW), .DIGEST_W(GW), .DEPTH(DEPTH), .SYNC_STAGES(SS)
  ) dut (
    .clk(clk), .initialise(initialise), .start(start), .busy(busy),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .activate_0r(activate_0r), .activate_0a(activate_0a),
    .data_0r(data_0r), .data_0a(data_0a), .data_0d(data_0d),
    .digest_0r(digest_0r), .digest_0a(digest_0a), .digest_0d(digest_0d),
    .dig_valid(dig_valid), .dig_data(dig_data),
    .fill_level(fill_level), .underrun(underrun)
  );

  always #5 clk = ~clk;
  always @(posedge activate_0r) act_rises++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  function automatic logic sig(input int w);
    case (w)
      0: return data_0a;
      1: return digest_0a;
      2: return dig_valid;
      3: return activate_0r;
      default: return busy;
    endcase
  endfunction

  task automatic wait_lvl(input int w, input logic lvl, output int cyc);
    cyc = 0;
    while (sig(w) !== lvl && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic push_byte(input logic [DW-1:0] b);
    wr_valid = 1'b1;
    wr_data = b;
    if (wr_ready === 1'b1) exp_q.push_back(b);
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic pull_one(input string name);
    int cyc;
    logic [DW-1:0] e;
    data_0r = 1'b1;
    wait_lvl(0, 1'b1, cyc);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    checks++;
    if (cyc != SS + 2 || data_0d !== e)
      $display("FAIL %s pull: data_0d=%h lat=%0d, want %h lat=%0d",
               name, data_0d, cyc, e, SS + 2);
    else passed++;
    data_0r = 1'b0;
    wait_lvl(0, 1'b0, cyc);
    checks++;
    if (data_0a !== 1'b0)
      $display("FAIL %s release: data_0a=%b want 0", name, data_0a);
    else passed++;
  endtask

  task automatic pull_with_push(input logic [DW-1:0] b);
    int cyc;
    int fl;
    logic [DW-1:0] e;
    data_0r = 1'b1;
    @(negedge clk);
    @(negedge clk);
    wr_valid = 1'b1;
    wr_data = b;
    if (wr_ready === 1'b1) exp_q.push_back(b);
    fl = int'(fill_level);
    @(negedge clk);
    wr_valid = 1'b0;
    checks++;
    if (int'(fill_level) != fl)
      $display("FAIL pushpop_fill: got %0d want %0d", fill_level, fl);
    else passed++;
    wait_lvl(0, 1'b1, cyc);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    checks++;
    if (cyc != 1 || data_0d !== e)
      $display("FAIL pushpop_data: got %h lat=%0d want %h lat=1",
               data_0d, cyc, e);
    else passed++;
    data_0r = 1'b0;
    wait_lvl(0, 1'b0, cyc);
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if ({activate_0r, data_0a, digest_0a, busy, dig_valid, underrun,
         wr_ready} !== 7'b0 || data_0d !== '0 || dig_data !== '0 ||
        fill_level !== '0)
      $display("FAIL reset_state: ctl=%b d=%h fill=%0d want all 0",
               {activate_0r, data_0a, digest_0a, busy, dig_valid, underrun,
                wr_ready}, data_0d, fill_level);
    else passed++;
    initialise = 1'b0;
    @(negedge clk);
    checks++;
    if (wr_ready !== 1'b1)
      $display("FAIL reset_release_ready: got %b want 1", wr_ready);
    else passed++;
  endtask

  task automatic test_basic;
    push_byte(8'h61);
    push_byte(8'h62);
    push_byte(8'h63);
    checks++;
    if (fill_level !== 5'd3)
      $display("FAIL basic_fill: got %0d want 3", fill_level);
    else passed++;
    for (int i = 0; i < 3; i++) pull_one("basic");
    checks++;
    if (fill_level !== 5'd0 || underrun !== 1'b0)
      $display("FAIL basic_end: fill=%0d underrun=%b want 0 0",
               fill_level, underrun);
    else passed++;
  endtask

  task automatic test_full_wrap;
    for (int i = 0; i < DEPTH; i++) push_byte(8'h10 + 8'(i));
    checks++;
    if (fill_level !== 5'd16 || wr_ready !== 1'b0)
      $display("FAIL full: fill=%0d ready=%b want 16 0", fill_level, wr_ready);
    else passed++;
    push_byte(8'hEE);
    checks++;
    if (fill_level !== 5'd16)
      $display("FAIL full_drop: fill=%0d want 16", fill_level);
    else passed++;
    pull_one("full_pop");
    push_byte(8'h40);
    checks++;
    if (fill_level !== 5'd16)
      $display("FAIL refill: fill=%0d want 16", fill_level);
    else passed++;
    pull_one("full_pop2");
    pull_with_push(8'h41);
    while (exp_q.size() > 0) pull_one("drain");
    checks++;
    if (fill_level !== 5'd0)
      $display("FAIL drain_fill: got %0d want 0", fill_level);
    else passed++;
  endtask

  task automatic test_underrun;
    int cyc;
    logic [DW-1:0] e;
    data_0r = 1'b1;
    repeat (8) @(negedge clk);
    checks++;
    if (data_0a !== 1'b0 || underrun !== 1'b1)
      $display("FAIL underrun_flag: ack=%b underrun=%b want 0 1",
               data_0a, underrun);
    else passed++;
    push_byte(8'hA5);
    wait_lvl(0, 1'b1, cyc);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    checks++;
    if (cyc != 2 || data_0d !== e || underrun !== 1'b1)
      $display("FAIL underrun_serve: d=%h lat=%0d ur=%b want %h 2 1",
               data_0d, cyc, underrun, e);
    else passed++;
    data_0r = 1'b0;
    wait_lvl(0, 1'b0, cyc);
    checks++;
    if (data_0a !== 1'b0)
      $display("FAIL underrun_release: ack=%b want 0", data_0a);
    else passed++;
  endtask

  task automatic dig_xfer(input logic [GW-1:0] v);
    int cyc;
    logic [GW-1:0] e;
    digest_0d = v;
    dig_q.push_back(v);
    digest_0r = 1'b1;
    wait_lvl(2, 1'b1, cyc);
    e = dig_q.pop_front();
    checks++;
    if (cyc != SS + 1 || dig_data !== e || digest_0a !== 1'b1)
      $display("FAIL dig_capture: lat=%0d ack=%b data=%h want lat=%0d %h",
               cyc, digest_0a, dig_data, SS + 1, e);
    else passed++;
    @(negedge clk);
    checks++;
    if (dig_valid !== 1'b0)
      $display("FAIL dig_pulse: dig_valid=%b want 0", dig_valid);
    else passed++;
    repeat (3) @(negedge clk);
    checks++;
    if (digest_0a !== 1'b1 || dig_valid !== 1'b0)
      $display("FAIL dig_hold_ack: ack=%b valid=%b want 1 0",
               digest_0a, dig_valid);
    else passed++;
    digest_0r = 1'b0;
    wait_lvl(1, 1'b0, cyc);
    digest_0d = ~v;
    @(negedge clk);
    checks++;
    if (digest_0a !== 1'b0 || dig_data !== e)
      $display("FAIL dig_release: ack=%b data=%h want 0 %h",
               digest_0a, dig_data, e);
    else passed++;
  endtask

  task automatic test_digest;
    dig_xfer(SHA_ABC);
    dig_xfer(SHA_EMPTY);
  endtask

  task automatic pulse_start;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_activate;
    int cyc;
    act_rises = 0;
    pulse_start();
    checks++;
    if (activate_0r !== 1'b1 || busy !== 1'b1)
      $display("FAIL act_req: r=%b busy=%b want 1 1", activate_0r, busy);
    else passed++;
    pulse_start();
    activate_0a = 1'b1;
    wait_lvl(3, 1'b0, cyc);
    checks++;
    if (activate_0r !== 1'b0 || busy !== 1'b1)
      $display("FAIL act_rel: r=%b busy=%b want 0 1", activate_0r, busy);
    else passed++;
    pulse_start();
    activate_0a = 1'b0;
    wait_lvl(4, 1'b0, cyc);
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || activate_0r !== 1'b0 || act_rises != 1)
      $display("FAIL act_done: busy=%b r=%b rises=%0d want 0 0 1",
               busy, activate_0r, act_rises);
    else passed++;
    pulse_start();
    activate_0a = 1'b1;
    wait_lvl(3, 1'b0, cyc);
    activate_0a = 1'b0;
    wait_lvl(4, 1'b0, cyc);
    checks++;
    if (busy !== 1'b0 || act_rises != 2)
      $display("FAIL act_second: busy=%b rises=%0d want 0 2",
               busy, act_rises);
    else passed++;
  endtask

  task automatic test_reset_mid;
    int cyc;
    logic [DW-1:0] e;
    push_byte(8'h55);
    push_byte(8'h66);
    digest_0d = SHA_ABC;
    data_0r = 1'b1;
    digest_0r = 1'b1;
    wait_lvl(0, 1'b1, cyc);
    wait_lvl(1, 1'b1, cyc);
    e = exp_q.pop_front();
    checks++;
    if (data_0a !== 1'b1 || digest_0a !== 1'b1 || data_0d !== e)
      $display("FAIL mid_pre: dack=%b gack=%b d=%h want 1 1 %h",
               data_0a, digest_0a, data_0d, e);
    else passed++;
    #2 initialise = 1'b1;
    #1;
    checks++;
    if (data_0a !== 1'b0 || digest_0a !== 1'b0 || fill_level !== '0 ||
        underrun !== 1'b0)
      $display("FAIL mid_reset: dack=%b gack=%b fill=%0d ur=%b want 0 0 0 0",
               data_0a, digest_0a, fill_level, underrun);
    else passed++;
    exp_q.delete();
    data_0r = 1'b0;
    digest_0r = 1'b0;
    @(negedge clk);
    initialise = 1'b0;
    @(negedge clk);
    checks++;
    if (wr_ready !== 1'b1 || data_0d !== '0)
      $display("FAIL mid_release: ready=%b d=%h want 1 00", wr_ready, data_0d);
    else passed++;
    push_byte(8'h3C);
    pull_one("post_reset");
    checks++;
    if (fill_level !== '0)
      $display("FAIL post_reset_fill: got %0d want 0", fill_level);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_wrap();
    test_underrun();
    test_digest();
    test_activate();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
